// File: rtl/ram_fifo_ctrl.sv
// 4-entry, 1-bit FIFO controller driving an external 4x1 RAM.
// Define RAM_FIFO_ERR_EN to enable the sticky protocol-error flag on err.
module ram_fifo_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       push_data,
    input  logic       pop,
    output logic       push_ack,
    output logic       pop_valid,
    output logic       pop_data,
    output logic       full,
    output logic       empty,
    output logic [2:0] count,
    output logic [1:0] a,
    output logic       wr,
    output logic       Din,
    output logic       Rd,
    input  logic       Dout,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, WR, RD, RDONE} state_t;

    state_t     state_q, state_d;
    logic [1:0] wptr_q, wptr_d;
    logic [1:0] rptr_q, rptr_d;
    logic [1:0] a_q, a_d;
    logic [2:0] count_q, count_d;
    logic       last_q, last_d;
    logic       pop_data_q, pop_data_d;
    logic       full_w, empty_w;
    logic       push_elig, pop_elig, do_wr, do_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            a_q        <= '0;
            count_q    <= '0;
            last_q     <= 1'b0;
            pop_data_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            a_q        <= a_d;
            count_q    <= count_d;
            last_q     <= last_d;
            pop_data_q <= pop_data_d;
        end
    end

    // When both requests are eligible, the op opposite to the last serviced one wins.
    always_comb begin
        full_w    = (count_q == 3'd4);
        empty_w   = (count_q == 3'd0);
        push_elig = push & ~full_w;
        pop_elig  = pop & ~empty_w;
        do_wr     = push_elig & (~pop_elig | last_q);
        do_rd     = pop_elig & (~push_elig | ~last_q);
    end

    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        a_d        = a_q;
        count_d    = count_q;
        last_d     = last_q;
        pop_data_d = pop_data_q;
        push_ack   = 1'b0;
        pop_valid  = 1'b0;
        wr         = 1'b0;
        Din        = 1'b0;
        Rd         = 1'b0;
        case (state_q)
            IDLE: begin
                if (do_wr) begin
                    state_d = WR;
                    a_d     = wptr_q;
                end else if (do_rd) begin
                    state_d = RD;
                    a_d     = rptr_q;
                end
            end
            WR: begin
                wr       = 1'b1;
                Din      = push_data;
                push_ack = 1'b1;
                wptr_d   = wptr_q + 2'd1;
                count_d  = count_q + 3'd1;
                last_d   = 1'b0;
                state_d  = IDLE;
            end
            RD: begin
                Rd         = 1'b1;
                pop_data_d = Dout;
                rptr_d     = rptr_q + 2'd1;
                count_d    = count_q - 3'd1;
                last_d     = 1'b1;
                state_d    = RDONE;
            end
            RDONE: begin
                pop_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign a        = a_q;
    assign count    = count_q;
    assign full     = full_w;
    assign empty    = empty_w;
    assign pop_data = pop_data_q;

`ifdef RAM_FIFO_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state_q == IDLE &&
                     ((push & full_w & ~pop) | (pop & empty_w & ~push))) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 One clock, clk; reset rst is synchronous and active-high; all state changes on the rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 push  input  1  write request, level; held until push_ack.
REQ-005 push_data  input  1  bit to write; stable while push is high.
REQ-006 pop  input  1  read request, level; held until pop_valid.
REQ-007 push_ack  output  1  one-cycle pulse, write performed this cycle.
REQ-008 pop_valid  output  1  one-cycle pulse, pop_data valid.
REQ-009 pop_data  output  1  bit read, held until next pop_valid.
REQ-010 full / empty  output  1 each  count==4 / count==0.
REQ-011 count  output  3  entries stored, 0..4.
REQ-012 a  output  2  address to downstream 4x1 ram.
REQ-013 wr / Din / Rd  output  1 each  ram write strobe, write data, read strobe.
REQ-014 Dout  input  1  ram read data, combinational from a while Rd=1.
REQ-015 err  output  1  sticky protocol error (see Configuration).

Function
REQ-016 FSM states IDLE, WR, RD, RDONE; requests sampled only in IDLE.
REQ-017 IDLE->WR when push and not full and (pop not eligible, or pop lost arbitration); IDLE->RD when pop and not empty and push not eligible or lost arbitration; otherwise stay IDLE.
REQ-018 WR (1 cycle): a=wptr, wr=1, Din=push_data, Rd=0, push_ack=1; at its end wptr+=1 mod 4, count+=1; next IDLE.
REQ-019 RD (1 cycle): a=rptr, Rd=1, wr=0; Dout captured into pop_data at end of cycle; rptr+=1 mod 4, count-=1; next RDONE.
REQ-020 RDONE (1 cycle): pop_valid=1; next IDLE.
REQ-021 Latency: push sampled edge N -> push_ack cycle N+1; pop sampled edge N -> Rd cycle N+1, pop_valid cycle N+2.
REQ-022 Requester drops push/pop by the edge ending the ack/valid cycle; one request serviced per handshake.
REQ-023 wr and Rd never high together; outside WR/RD, wr=Rd=0, a holds last value, Din=0.
REQ-024 Simultaneous push and pop with 1<=count<=3: alternate priority; toggle bit 'last' (0=write) set by each serviced op; op opposite to 'last' wins; loser waits in IDLE.
REQ-025 Simultaneous push and pop, count==0: push wins; count==4: pop wins.
REQ-026 Push while full alone, or pop while empty alone: no ack, no ram strobe, no pointer/count change.
REQ-027 Pointers wrap 3->0; count never exceeds 4 or goes below 0.
REQ-028 full, empty, count are registered and reflect state after last completed op.

Reset
REQ-029 rst=1 at any edge, including during WR/RD/RDONE: next state IDLE, wptr=rptr=0, count=0, last=0, empty=1, full=0, push_ack=pop_valid=0, pop_data=0, a=0, wr=Rd=Din=0, err=0.
REQ-030 ram contents not cleared; a read interrupted by reset produces no pop_valid.

Configuration
REQ-031 Macro RAM_FIFO_ERR_EN defined: err set to 1 on any IDLE cycle with push&full&!pop or pop&empty&!push; sticky until rst.
REQ-032 RAM_FIFO_ERR_EN undefined: err tied to 0; no error logic; all other behaviour identical.

Verification
REQ-033 After rst, push 1,0,1,1 -> push_ack each one cycle after sampling; a=0,1,2,3 with wr=1; count=4, full=1.
REQ-034 From full, pop x4 -> Rd at a=0,1,2,3; pop_data 1,0,1,1 on pop_valid two cycles after sampling; empty=1.
REQ-035 count=2, push and pop held together, last=0 -> read serviced first, then write; count returns to 2.
REQ-036 Push 5th bit when full -> no push_ack, wr stays 0, count=4; with RAM_FIFO_ERR_EN err=1 until rst, without err=0.
REQ-037 6 push/pop pairs across wrap -> wptr/rptr pass 3->0; data order preserved.
REQ-038 rst asserted during RD -> no pop_valid; next cycle count=0, empty=1, all strobes 0.
